// File: rtl/lcm_unit_if.sv
// Operand/result bundle shared between the gcd core side and the LCM stage.
// The master drives the gcd operands and flags; the slave returns the LCM result.
interface lcm_unit_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0]   A_in;
   logic [WIDTH-1:0]   B_in;
   logic [WIDTH-1:0]   gcd_in;
   logic               gcd_done;
   logic [2*WIDTH-1:0] out;
   logic               done;
   logic               err;

   modport master (
      output A_in, B_in, gcd_in, gcd_done,
      input  out, done, err
   );

   modport slave (
      input  A_in, B_in, gcd_in, gcd_done,
      output out, done, err
   );
endinterface

// File: rtl/lcm_unit.sv
// LCM(A,B) = (A / GCD) * B using a restoring divider followed by a shift-add
// multiplier; fixed latency of 2*WIDTH+1 cycles from the gcd_done rising edge.
module lcm_unit #(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   lcm_unit_if.slave  bus,
   output logic [1:0] state_dbg
);
   // Handshake: a computation starts on a rising edge of gcd_done seen in IDLE
   // or FIN; done is a level that stays high with out/err until the next start.
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIV  = 2'd1;
   localparam logic [1:0] S_MUL  = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               gcd_done_d_q, gcd_done_d_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   g_q, g_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] out_q, out_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               start;
   logic               div_err;
   logic [WIDTH:0]     rem_sh;

   assign start     = bus.gcd_done && !gcd_done_d_q;
   assign div_err   = (g_q == '0) || (rem_q != '0);
   // quo_q starts out holding the dividend and fills with quotient bits from the LSB.
   assign rem_sh    = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
   assign state_dbg = state_q;
   assign bus.out   = out_q;
   assign bus.done  = done_q;
   assign bus.err   = err_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      gcd_done_d_d = bus.gcd_done;
      b_d          = b_q;
      g_d          = g_q;
      quo_d        = quo_q;
      rem_d        = rem_q;
      acc_d        = acc_q;
      mcand_d      = mcand_q;
      out_d        = out_q;
      done_d       = done_q;
      err_d        = err_q;
      case (state_q)
         S_IDLE, S_FIN: begin
            if (state_q == S_FIN && !done_q) begin
               done_d = 1'b1;
               err_d  = div_err;
               out_d  = div_err ? '0 : acc_q;
            end
            if (start) begin
               state_d = S_DIV;
               cnt_d   = CW'(WIDTH);
               quo_d   = bus.A_in;
               b_d     = bus.B_in;
               g_d     = bus.gcd_in;
               rem_d   = '0;
               acc_d   = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         S_DIV: begin
            // A zero divisor always "fits"; the result is flagged as err in FIN.
            if (rem_sh >= {1'b0, g_q}) begin
               rem_d = rem_sh - {1'b0, g_q};
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = rem_sh;
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = S_MUL;
               cnt_d   = CW'(WIDTH);
               acc_d   = '0;
               mcand_d = {{WIDTH{1'b0}}, b_q};
            end
         end
         S_MUL: begin
            if (quo_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            quo_d   = quo_q >> 1;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = S_FIN;
               cnt_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         gcd_done_d_q <= 1'b0;
         b_q          <= '0;
         g_q          <= '0;
         quo_q        <= '0;
         rem_q        <= '0;
         acc_q        <= '0;
         mcand_q      <= '0;
         out_q        <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         gcd_done_d_q <= gcd_done_d_d;
         b_q          <= b_d;
         g_q          <= g_d;
         quo_q        <= quo_d;
         rem_q        <= rem_d;
         acc_q        <= acc_d;
         mcand_q      <= mcand_d;
         out_q        <= out_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end
endmodule

// File: tb/tb_lcm_unit.sv
// Directed bench for lcm_unit: vector table plus hand-written sequences for
// hold, busy-time restart, and reset during the multiply phase.
module tb_lcm_unit;
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  g;
    logic [15:0] out;
    logic        err;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         n_vec;
  int         n_err;
  logic [15:0] last_out;
  vec_t       vecs[10];

  lcm_unit_if #(.WIDTH(8)) bus ();

  lcm_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the current point until done rises; 40 = expired.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (bus.done === 1'b1) break;
    end
  endtask

  // Drives a fresh rising edge of gcd_done; returns positioned just after edge 0.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g);
    bus.A_in = a;
    bus.B_in = b;
    bus.gcd_in = g;
    bus.gcd_done = 1'b0;
    tick();
    bus.gcd_done = 1'b1;
    tick();
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int lat;
    start_op(v.a, v.b, v.g);
    check({tag, " done_clr"}, 32'(bus.done), 32'd0);
    check({tag, " state_div"}, 32'(state_dbg), 32'd1);
    check({tag, " out_hold"}, 32'(bus.out), 32'(last_out));
    wait_done(lat);
    check({tag, " latency"}, 32'(lat), 32'd17);
    check({tag, " out"}, 32'(bus.out), 32'(v.out));
    check({tag, " err"}, 32'(bus.err), 32'(v.err));
    last_out = v.out;
  endtask

  initial begin
    int lat;
    int bad;
    n_vec = 0;
    n_err = 0;
    last_out = '0;

    vecs[0] = '{a: 8'd70,  b: 8'd140, g: 8'd70,  out: 16'd140,   err: 1'b0};
    vecs[1] = '{a: 8'd18,  b: 8'd170, g: 8'd2,   out: 16'd1530,  err: 1'b0};
    vecs[2] = '{a: 8'd180, b: 8'd160, g: 8'd20,  out: 16'd1440,  err: 1'b0};
    vecs[3] = '{a: 8'd255, b: 8'd254, g: 8'd1,   out: 16'd64770, err: 1'b0};
    vecs[4] = '{a: 8'd0,   b: 8'd0,   g: 8'd0,   out: 16'd0,     err: 1'b1};
    vecs[5] = '{a: 8'd10,  b: 8'd4,   g: 8'd3,   out: 16'd0,     err: 1'b1};
    vecs[6] = '{a: 8'd0,   b: 8'd9,   g: 8'd9,   out: 16'd0,     err: 1'b0};
    vecs[7] = '{a: 8'd12,  b: 8'd18,  g: 8'd6,   out: 16'd36,    err: 1'b0};
    vecs[8] = '{a: 8'd255, b: 8'd255, g: 8'd255, out: 16'd255,   err: 1'b0};
    vecs[9] = '{a: 8'd200, b: 8'd0,   g: 8'd200, out: 16'd0,     err: 1'b0};

    rst_n = 1'b0;
    bus.A_in = '0;
    bus.B_in = '0;
    bus.gcd_in = '0;
    bus.gcd_done = 1'b0;
    repeat (3) tick();
    check("reset out", 32'(bus.out), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    check("reset state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    tick();

    // first vector, then done/out must hold for 100 cycles
    apply_vec(vecs[0], "v0");
    bad = 0;
    repeat (100) begin
      tick();
      if (bus.done !== 1'b1 || bus.out !== 16'd140 || state_dbg !== 2'd3) bad++;
    end
    check("hold 100 cycles bad count", 32'(bad), 32'd0);

    for (int i = 1; i < 10; i++) begin
      apply_vec(vecs[i], $sformatf("v%0d", i));
    end

    // gcd_done re-pulsed and operands changed during DIV: must be ignored
    start_op(8'd18, 8'd170, 8'd2);
    tick();
    bus.gcd_done = 1'b0;
    tick();
    bus.gcd_done = 1'b1;
    bus.A_in = 8'd99;
    bus.B_in = 8'd7;
    bus.gcd_in = 8'd3;
    check("busy state_div", 32'(state_dbg), 32'd1);
    wait_done(lat);
    check("busy latency", 32'(lat), 32'd15);
    check("busy out", 32'(bus.out), 32'd1530);
    check("busy err", 32'(bus.err), 32'd0);
    bad = 0;
    repeat (40) begin
      tick();
      if (bus.done !== 1'b1 || bus.out !== 16'd1530) bad++;
    end
    check("busy no restart bad count", 32'(bad), 32'd0);
    last_out = 16'd1530;

    // reset during MUL aborts immediately; gcd_done high at release starts anew
    start_op(8'd255, 8'd254, 8'd1);
    repeat (11) tick();
    check("rst mid state_mul", 32'(state_dbg), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst mid out", 32'(bus.out), 32'd0);
    check("rst mid done", 32'(bus.done), 32'd0);
    check("rst mid err", 32'(bus.err), 32'd0);
    check("rst mid state", 32'(state_dbg), 32'd0);
    bus.A_in = 8'd12;
    bus.B_in = 8'd18;
    bus.gcd_in = 8'd6;
    repeat (3) tick();
    check("rst held done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst restart state_div", 32'(state_dbg), 32'd1);
    wait_done(lat);
    check("rst restart latency", 32'(lat), 32'd17);
    check("rst restart out", 32'(bus.out), 32'd36);
    check("rst restart err", 32'(bus.err), 32'd0);
    bus.gcd_done = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
